// File: rtl/frame_sequencer_pkg.sv
// Shared encodings for the frame pass sequencer: state enum, object indices
// and the object-to-select mapping used by the top-level FSM.
package frame_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_WAIT_FRAME = 4'd1,
        ST_ER_B       = 4'd2,
        ST_ER_A       = 4'd3,
        ST_ER_C       = 4'd4,
        ST_ER_H       = 4'd5,
        ST_UPDATE     = 4'd6,
        ST_DR_B       = 4'd7,
        ST_DR_A       = 4'd8,
        ST_DR_C       = 4'd9,
        ST_DR_H       = 4'd10,
        ST_CHECK      = 4'd11,
        ST_EVAL       = 4'd12,
        ST_GAME_OVER  = 4'd13
    } state_t;

    localparam logic [1:0] OBJ_B    = 2'd0;
    localparam logic [1:0] OBJ_A    = 2'd1;
    localparam logic [1:0] OBJ_C    = 2'd2;
    localparam logic [1:0] OBJ_HELI = 2'd3;

    // Select vector is {select4, select3, select2, select1} = {C, heli, A, B}.
    function automatic logic [3:0] obj_select(input logic [1:0] obj);
        case (obj)
            OBJ_B:    return 4'b0001;
            OBJ_A:    return 4'b0010;
            OBJ_HELI: return 4'b0100;
            default:  return 4'b1000;
        endcase
    endfunction

    function automatic logic is_obj_state(input state_t s);
        return s inside {ST_ER_B, ST_ER_A, ST_ER_C, ST_ER_H,
                         ST_DR_B, ST_DR_A, ST_DR_C, ST_DR_H};
    endfunction

    function automatic logic [1:0] obj_of_state(input state_t s);
        case (s)
            ST_ER_B, ST_DR_B: return OBJ_B;
            ST_ER_A, ST_DR_A: return OBJ_A;
            ST_ER_C, ST_DR_C: return OBJ_C;
            default:          return OBJ_HELI;
        endcase
    endfunction

endpackage

// File: rtl/frame_sequencer_tick_divider.sv
// Frame-rate divider: free-running count over 0..TICK_CYCLES-1 with a
// one-cycle tick on the terminal count.
module frame_sequencer_tick_divider #(
    parameter int TICK_CYCLES = 833333
) (
    input  logic i_clock,
    input  logic i_resetn,
    output logic o_tick
);
    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    assign w_tc   = (r_cnt == TC);
    assign o_tick = w_tc;

    // Count up and wrap to zero at terminal count.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) r_cnt <= '0;
        else if (w_tc) r_cnt <= '0;
        else           r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/frame_sequencer.sv
// Frame pass master: erases and redraws the four objects, pulses the
// position update, runs the collision check and scores or ends the game.
//
// state       | meaning
// IDLE        | after reset, waiting for go
// WAIT_FRAME  | waiting for a frame tick (or a tick that arrived mid-pass)
// ER_B..ER_H  | erase block B, A, C, heli in turn
// UPDATE      | one-cycle position update pulse
// DR_B..DR_H  | redraw block B, A, C, heli in turn
// CHECK       | collision check requested from the mux
// EVAL        | score the frame or latch game over
// GAME_OVER   | collision seen, waiting for go
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int TICK_CYCLES  = 833333,
    parameter int DRAW_TIMEOUT = 256,
    parameter int SCORE_W      = 16
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               go,
    input  logic               done_b,
    input  logic               done_a,
    input  logic               done_c,
    input  logic               done_heli,
    input  logic               doneCheck,
    input  logic               collision,
    output logic               select1,
    output logic               select2,
    output logic               select3,
    output logic               select4,
    output logic               check,
    output logic               erase,
    output logic               plot,
    output logic               update,
    output logic               game_over,
    output logic               draw_fault,
    output logic [SCORE_W-1:0] score
);
    localparam int TW = (DRAW_TIMEOUT > 1) ? $clog2(DRAW_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(DRAW_TIMEOUT - 1);

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_sel, w_sel_nxt;
    logic                r_erase, w_erase_nxt;
    logic                r_check, w_check_nxt;
    logic                r_update, w_update_nxt;
    logic                r_pend, r_hit, r_game_over, r_fault;
    logic [SCORE_W-1:0]  r_score;
    logic [TW-1:0]       r_tmo;
    logic                w_tick, w_tmo_done, w_done_cur, w_obj_adv;
    logic                w_go_accept, w_fault_set;
    logic [3:0]          w_done_sel;

    frame_sequencer_tick_divider #(.TICK_CYCLES(TICK_CYCLES)) u_tick_divider (
        .i_clock  (clock),
        .i_resetn (resetn),
        .o_tick   (w_tick)
    );

    // Done lines arranged in select order {C, heli, A, B}.
    assign w_done_sel  = {done_c, done_heli, done_a, done_b};
    assign w_done_cur  = |(r_sel & w_done_sel);
    assign w_tmo_done  = (r_tmo == '0);
    assign w_obj_adv   = w_done_cur || w_tmo_done;
    assign w_go_accept = go && (r_state == ST_IDLE || r_state == ST_GAME_OVER);
    assign w_fault_set = (is_obj_state(r_state) && w_tmo_done && !w_done_cur) ||
                         (r_state == ST_CHECK && w_tmo_done && !doneCheck);

    // Next-state decode, then output values for the state being entered.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_GAME_OVER: if (go) w_state_nxt = ST_WAIT_FRAME;
            ST_WAIT_FRAME: if (w_tick || r_pend) w_state_nxt = ST_ER_B;
            ST_ER_B:   if (w_obj_adv) w_state_nxt = ST_ER_A;
            ST_ER_A:   if (w_obj_adv) w_state_nxt = ST_ER_C;
            ST_ER_C:   if (w_obj_adv) w_state_nxt = ST_ER_H;
            ST_ER_H:   if (w_obj_adv) w_state_nxt = ST_UPDATE;
            ST_UPDATE: w_state_nxt = ST_DR_B;
            ST_DR_B:   if (w_obj_adv) w_state_nxt = ST_DR_A;
            ST_DR_A:   if (w_obj_adv) w_state_nxt = ST_DR_C;
            ST_DR_C:   if (w_obj_adv) w_state_nxt = ST_DR_H;
            ST_DR_H:   if (w_obj_adv) w_state_nxt = ST_CHECK;
            ST_CHECK:  if (doneCheck || w_tmo_done) w_state_nxt = ST_EVAL;
            ST_EVAL:   w_state_nxt = r_hit ? ST_GAME_OVER : ST_WAIT_FRAME;
            default:   w_state_nxt = ST_IDLE;
        endcase

        w_sel_nxt    = is_obj_state(w_state_nxt) ? obj_select(obj_of_state(w_state_nxt)) : 4'b0000;
        w_erase_nxt  = w_state_nxt inside {ST_ER_B, ST_ER_A, ST_ER_C, ST_ER_H};
        w_check_nxt  = (w_state_nxt == ST_CHECK);
        w_update_nxt = (w_state_nxt == ST_UPDATE);
    end

    // State and registered strobes; outputs follow the state they belong to.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_sel    <= 4'b0000;
            r_erase  <= 1'b0;
            r_check  <= 1'b0;
            r_update <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_erase  <= w_erase_nxt;
            r_check  <= w_check_nxt;
            r_update <= w_update_nxt;
        end
    end

    // Per-state timeout: reload on every state change, count down to zero.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                     r_tmo <= '0;
        else if (w_state_nxt != r_state) r_tmo <= TMO_LOAD;
        else if (!w_tmo_done)            r_tmo <= r_tmo - 1'b1;
    end

    // Frame bookkeeping. A restart drops any tick left over from the last
    // game so the first pass waits for a fresh tick.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pend      <= 1'b0;
            r_hit       <= 1'b0;
            r_game_over <= 1'b0;
            r_fault     <= 1'b0;
            r_score     <= '0;
        end else begin
            if (w_go_accept)
                r_pend <= 1'b0;
            else if (r_state == ST_WAIT_FRAME && w_state_nxt == ST_ER_B)
                r_pend <= 1'b0;
            else if (w_tick && r_state != ST_WAIT_FRAME)
                r_pend <= 1'b1;

            if (w_go_accept)
                r_hit <= 1'b0;
            else if (r_state == ST_CHECK && doneCheck)
                r_hit <= collision;
            else if (r_state == ST_CHECK && w_tmo_done)
                r_hit <= 1'b0;

            if (w_go_accept)
                r_game_over <= 1'b0;
            else if (r_state == ST_EVAL && r_hit)
                r_game_over <= 1'b1;

            if (w_go_accept)
                r_score <= '0;
            else if (r_state == ST_EVAL && !r_hit && r_score != {SCORE_W{1'b1}})
                r_score <= r_score + 1'b1;

            if (w_fault_set)
                r_fault <= 1'b1;
        end
    end

    assign select1    = r_sel[0];
    assign select2    = r_sel[1];
    assign select3    = r_sel[2];
    assign select4    = r_sel[3];
    assign erase      = r_erase;
    assign check      = r_check;
    assign update     = r_update;
    assign plot       = |(r_sel & ~w_done_sel);
    assign game_over  = r_game_over;
    assign draw_fault = r_fault;
    assign score      = r_score;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed vector bench for frame_sequencer with TICK_CYCLES=20,
// DRAW_TIMEOUT=8, SCORE_W=4. Each scenario starts from reset; vectors are
// keyed by the number of clock edges since reset release.
module tb_frame_sequencer;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       go = 1'b0, coll = 1'b0, hold_a = 1'b0, hold_c = 1'b0, hold_chk = 1'b0;
    logic       done_b, done_a, done_c, done_heli, doneCheck;
    logic       select1, select2, select3, select4;
    logic       check, erase, plot, update, game_over, draw_fault;
    logic [3:0] score;

    int unsigned lat = 3;
    int unsigned dcnt [4];
    int          cyc;
    int          n_vec = 0;
    int          n_err = 0;

    localparam logic [3:0] S_0 = 4'b0000, S_B = 4'b0001, S_A = 4'b0010, S_H = 4'b0100, S_C = 4'b1000;
    localparam logic [5:0] F_0 = 6'b000000, F_ER = 6'b100000, F_PL = 6'b010000, F_UP = 6'b001000,
                           F_CK = 6'b000100, F_GO = 6'b000010, F_FT = 6'b000001;
    localparam logic [4:0] I_0 = 5'b00000, I_GO = 5'b10000, I_COL = 5'b01000, I_HA = 5'b00100,
                           I_HC = 5'b00010, I_HK = 5'b00001;

    typedef struct {
        int         cyc;
        logic [4:0] in;
        logic [3:0] sel;
        logic [5:0] fl;
        logic [3:0] score;
    } vec_t;
    vec_t tbl[$];

    frame_sequencer #(.TICK_CYCLES(20), .DRAW_TIMEOUT(8), .SCORE_W(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .go         (go),
        .done_b     (done_b),
        .done_a     (done_a),
        .done_c     (done_c),
        .done_heli  (done_heli),
        .doneCheck  (doneCheck),
        .collision  (coll),
        .select1    (select1),
        .select2    (select2),
        .select3    (select3),
        .select4    (select4),
        .check      (check),
        .erase      (erase),
        .plot       (plot),
        .update     (update),
        .game_over  (game_over),
        .draw_fault (draw_fault),
        .score      (score)
    );

    always #5 clock = ~clock;

    logic [3:0] w_sel;
    assign w_sel = {select4, select3, select2, select1};

    // Edge counter since reset release.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Drawer model: done rises lat cycles after the object's select rises.
    always @(posedge clock or negedge resetn) begin
        for (int k = 0; k < 4; k++) begin
            if (!resetn)       dcnt[k] <= 0;
            else if (w_sel[k]) dcnt[k] <= dcnt[k] + 1;
            else               dcnt[k] <= 0;
        end
    end

    assign done_b    = w_sel[0] && (dcnt[0] >= lat);
    assign done_a    = w_sel[1] && (dcnt[1] >= lat) && !hold_a;
    assign done_heli = w_sel[2] && (dcnt[2] >= lat);
    assign done_c    = w_sel[3] && (dcnt[3] >= lat) && !hold_c;
    assign doneCheck = check && !hold_chk;

    function automatic void add(int c, logic [4:0] in, logic [3:0] sel, logic [5:0] fl, logic [3:0] sc);
        vec_t t;
        t.cyc = c; t.in = in; t.sel = sel; t.fl = fl; t.score = sc;
        tbl.push_back(t);
    endfunction

    task automatic do_reset(input int unsigned l);
        @(negedge clock);
        resetn = 1'b0;
        {go, coll, hold_a, hold_c, hold_chk} = 5'b00000;
        lat = l;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic run_table(input string name);
        logic [13:0] act, exp;
        int guard;
        for (int i = 0; i < tbl.size(); i++) begin
            guard = 0;
            while (cyc < tbl[i].cyc && guard < 2000) begin
                @(negedge clock);
                guard++;
            end
            n_vec++;
            if (cyc != tbl[i].cyc) begin
                n_err++;
                $display("FAIL %s[%0d] sample point: at edge %0d, required edge %0d", name, i, cyc, tbl[i].cyc);
            end else begin
                act = {w_sel, erase, plot, update, check, game_over, draw_fault, score};
                exp = {tbl[i].sel, tbl[i].fl, tbl[i].score};
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL %s[%0d] edge %0d {sel4321,er,pl,up,ck,go,ft,score}: got %b required %b",
                             name, i, cyc, act, exp);
                end
            end
            {go, coll, hold_a, hold_c, hold_chk} = tbl[i].in;
        end
        tbl.delete();
    endtask

    initial begin
        // Clean frames, select order, go ignored mid-pass, score saturation.
        do_reset(3);
        add(1,  I_GO, S_0, F_0, 0);
        add(2,  I_0,  S_0, F_0, 0);
        add(19, I_0,  S_0, F_0, 0);
        add(20, I_0,  S_B, F_ER | F_PL, 0);
        add(23, I_0,  S_B, F_ER, 0);
        add(24, I_0,  S_A, F_ER | F_PL, 0);
        add(28, I_0,  S_C, F_ER | F_PL, 0);
        add(30, I_GO, S_C, F_ER | F_PL, 0);
        add(31, I_0,  S_C, F_ER, 0);
        add(32, I_0,  S_H, F_ER | F_PL, 0);
        add(35, I_0,  S_H, F_ER, 0);
        add(36, I_0,  S_0, F_UP, 0);
        add(37, I_0,  S_B, F_PL, 0);
        add(41, I_0,  S_A, F_PL, 0);
        add(45, I_0,  S_C, F_PL, 0);
        add(49, I_0,  S_H, F_PL, 0);
        add(52, I_0,  S_H, F_0, 0);
        add(53, I_0,  S_0, F_CK, 0);
        add(54, I_0,  S_0, F_0, 0);
        add(55, I_0,  S_0, F_0, 1);
        add(56, I_0,  S_B, F_ER | F_PL, 1);
        add(523, I_0, S_0, F_0, 14);
        add(558, I_0, S_0, F_0, 14);
        add(559, I_0, S_0, F_0, 15);
        add(594, I_0, S_0, F_0, 15);
        add(595, I_0, S_0, F_0, 15);
        add(596, I_0, S_B, F_ER | F_PL, 15);
        run_table("clean");

        // Collision on the second frame, then restart with go.
        do_reset(3);
        add(1,   I_GO,  S_0, F_0, 0);
        add(2,   I_0,   S_0, F_0, 0);
        add(53,  I_0,   S_0, F_CK, 0);
        add(55,  I_0,   S_0, F_0, 1);
        add(56,  I_COL, S_B, F_ER | F_PL, 1);
        add(89,  I_COL, S_0, F_CK, 1);
        add(90,  I_COL, S_0, F_0, 1);
        add(91,  I_COL, S_0, F_GO, 1);
        add(95,  I_GO,  S_0, F_GO, 1);
        add(96,  I_0,   S_0, F_0, 0);
        add(99,  I_0,   S_0, F_0, 0);
        add(100, I_0,   S_B, F_ER | F_PL, 0);
        run_table("collide");

        // done_a stuck low on the first erase pass: timeout and sticky fault.
        do_reset(3);
        add(1,  I_GO | I_HA, S_0, F_0, 0);
        add(2,  I_HA, S_0, F_0, 0);
        add(23, I_HA, S_B, F_ER, 0);
        add(24, I_HA, S_A, F_ER | F_PL, 0);
        add(31, I_HA, S_A, F_ER | F_PL, 0);
        add(32, I_0,  S_C, F_ER | F_PL | F_FT, 0);
        add(59, I_0,  S_0, F_FT, 1);
        add(60, I_0,  S_B, F_ER | F_PL | F_FT, 1);
        add(95, I_0,  S_0, F_FT, 2);
        run_table("timeout");

        // Long pass spanning two ticks: one catch-up pass, then a fresh wait.
        do_reset(0);
        add(1,  I_GO | I_HA | I_HC | I_HK, S_0, F_0, 0);
        add(2,  I_HA | I_HC | I_HK, S_0, F_0, 0);
        add(20, I_HA | I_HC | I_HK, S_B, F_ER, 0);
        add(21, I_HA | I_HC | I_HK, S_A, F_ER | F_PL, 0);
        add(28, I_HA | I_HC | I_HK, S_A, F_ER | F_PL, 0);
        add(29, I_HA | I_HC | I_HK, S_C, F_ER | F_PL | F_FT, 0);
        add(36, I_HA | I_HC | I_HK, S_C, F_ER | F_PL | F_FT, 0);
        add(37, I_HA | I_HC | I_HK, S_H, F_ER | F_FT, 0);
        add(38, I_HA | I_HC | I_HK, S_0, F_UP | F_FT, 0);
        add(39, I_HA | I_HC | I_HK, S_B, F_FT, 0);
        add(40, I_HA | I_HC | I_HK, S_A, F_PL | F_FT, 0);
        add(48, I_HA | I_HC | I_HK, S_C, F_PL | F_FT, 0);
        add(56, I_HA | I_HC | I_HK, S_H, F_FT, 0);
        add(57, I_HA | I_HC | I_HK, S_0, F_CK | F_FT, 0);
        add(64, I_HA | I_HC | I_HK, S_0, F_CK | F_FT, 0);
        add(65, I_0, S_0, F_FT, 0);
        add(66, I_0, S_0, F_FT, 1);
        add(67, I_0, S_B, F_ER | F_FT, 1);
        add(68, I_0, S_A, F_ER | F_FT, 1);
        add(76, I_0, S_0, F_CK | F_FT, 1);
        add(77, I_0, S_0, F_FT, 1);
        add(78, I_0, S_0, F_FT, 2);
        add(79, I_0, S_0, F_FT, 2);
        add(80, I_0, S_B, F_ER | F_FT, 2);
        run_table("ticks");

        // Asynchronous reset in the middle of drawing block A.
        do_reset(3);
        add(1,  I_GO, S_0, F_0, 0);
        add(2,  I_0,  S_0, F_0, 0);
        add(42, I_0,  S_A, F_PL, 0);
        run_table("pre_rst");
        #1 resetn = 1'b0;
        #1;
        n_vec++;
        if ({w_sel, erase, plot, update, check, game_over, draw_fault, score} !== 14'b0) begin
            n_err++;
            $display("FAIL async_rst outputs: got %b required all zero",
                     {w_sel, erase, plot, update, check, game_over, draw_fault, score});
        end
        @(negedge clock);
        resetn = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Master controller for one frame pass. It drives the object select lines and the collision-check request into the shared drawing/collision mux, and consumes the mux's doneCheck and collision results.
- Per frame tick the pass is: erase blocks B, A, C and the heli; pulse a position update; redraw B, A, C and the heli; run the collision check; then score the frame or end the game.
- Sits between the internal frame-rate divider, the four object drawers and the VGA-facing mux.

Parameters:
- TICK_CYCLES, 833333, clock cycles per frame tick (50 MHz / 60).
- DRAW_TIMEOUT, 256, max cycles in any object or check state before forced advance.
- SCORE_W, 16, score counter width.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- go  in  1  start/restart request, sampled only in IDLE and GAME_OVER.
- done_b, done_a, done_c, done_heli  in  1 each  drawer finished current erase/draw pass.
- doneCheck  in  1  mux collision evaluation complete.
- collision  in  1  mux collision result, valid while doneCheck=1.
- select1  out  1  block B selected.
- select2  out  1  block A selected.
- select3  out  1  heli selected.
- select4  out  1  block C selected.
- check  out  1  collision-check request to mux.
- erase  out  1  drawers paint background colour this pass.
- plot  out  1  VGA write enable.
- update  out  1  one-cycle pulse to position logic.
- game_over  out  1  collision latched.
- draw_fault  out  1  sticky: some state hit DRAW_TIMEOUT.
- score  out  SCORE_W  frames survived.

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE.
  - All outputs go to 0 immediately, including the selects; this holds mid-draw too.
  - Score, tick counter, tick pending flag, hit flag and timeout counter are cleared.
- Tick divider:
  - Free-runs from reset over 0..TICK_CYCLES-1; emits a one-cycle tick on wrap.
  - A tick outside WAIT_FRAME sets the pending flag. Multiple ticks collapse into one.
- State order: IDLE, WAIT_FRAME, ER_B, ER_A, ER_C, ER_H, UPDATE, DR_B, DR_A, DR_C, DR_H, CHECK, EVAL, GAME_OVER.
- IDLE: go=1 moves to WAIT_FRAME, with score=0, hit=0 and game_over=0.
- WAIT_FRAME: on tick or pending flag, clear pending and move to ER_B.
- Object states (ER_x and DR_x):
  - Exactly the matching select is high: B→select1, A→select2, heli→select3, C→select4. The selects are registered and never more than one high.
  - erase=1 in ER_x states only.
  - plot = select active AND matching done=0.
  - When done is sampled 1, the next cycle enters the following state.
  - The timeout counter is cleared on entering each state. At DRAW_TIMEOUT cycles without done, set draw_fault and advance.
- UPDATE: exactly 1 cycle with update=1 and all selects 0, then DR_B.
- CHECK:
  - check=1, all selects 0, plot=0.
  - The first cycle with doneCheck=1 registers hit ← collision and moves to EVAL.
  - On timeout: set draw_fault, hit=0, move to EVAL.
- EVAL (1 cycle):
  - hit=1 → GAME_OVER with game_over=1, score held.
  - Otherwise score += 1, saturating at all-ones, then WAIT_FRAME.
- GAME_OVER: all selects, check and plot are 0. go=1 clears score, hit and game_over and moves to WAIT_FRAME.
- go is ignored in all other states. draw_fault clears only on reset.
- Minimum pass latency with done returned in 1 cycle: 8×2 + 1 + 1 + 1 = 19 cycles.

Decomposition:
- Shared package holds:
  - the state encoding localparams;
  - object index constants OBJ_B=0, OBJ_A=1, OBJ_C=2, OBJ_HELI=3;
  - a function mapping object index to the one-hot select vector.
- One sub-module: tick_divider (TICK_CYCLES parameter, outputs the tick pulse).

Test Plan:
All scenarios use TICK_CYCLES=20, DRAW_TIMEOUT=8, SCORE_W=4, and drawers return done 3 cycles after their select rises.
1. Reset, then pulse go, then wait for tick → all outputs 0 until tick; next cycle select1=1, erase=1, plot=1.
2. One full frame, collision=0 → select order 1,2,4,3 with erase=1; update high exactly 1 cycle; same order with erase=0; check=1 one cycle; score 0→1.
3. collision=1 during CHECK → game_over=1 the cycle after EVAL, score unchanged; pulse go → score=0, game_over=0, next tick starts ER_B.
4. done_a held 0 → select2 high exactly 8 cycles, draw_fault=1, then select4=1; draw_fault stays 1 after later good frames.
5. Two ticks during one pass → exactly one extra pass starts immediately after EVAL, then waits for a fresh tick.
6. 16 clean frames → score saturates at 15. Separately, assert resetn low mid DR_A → select2 and plot drop without a clock edge.
